// File: rtl/mmio_bus_controller.sv
`default_nettype none
// =============================================================================
// Module      : mmio_bus_controller
// Description : Splits CPU loads/stores between data memory and an APB-style
//               MMIO bus (UART, ethernet) with stall, timeout and bus error.
// Revision    : 1.0 - initial release
// =============================================================================
module mmio_bus_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic        we_mem,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        bus_error,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        psel_uart,
    output logic        psel_eth,
    output logic        penable,
    input  logic [31:0] prdata_uart,
    input  logic [31:0] prdata_eth,
    input  logic        pready_uart,
    input  logic        pready_eth
);

    localparam logic [7:0]  c_LAST_WAIT   = 8'(TIMEOUT - 1);
    localparam logic [28:0] c_UART_WORD8  = 29'h1FFF_E000;
    localparam logic [28:0] c_ETH_WORD8   = 29'h1FFF_E001;
    localparam logic [31:0] c_UNMAPPED    = 32'hFFFF_0010;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_paddr, w_paddr_nxt;
    logic [31:0] r_pwdata, w_pwdata_nxt;
    logic        r_pwrite, w_pwrite_nxt;
    logic        r_tgt_eth, w_tgt_eth_nxt;
    logic [7:0]  r_count, w_count_nxt;
    logic [31:0] r_readdata, w_readdata_nxt;
    logic        r_bus_error, w_bus_error_nxt;

    logic w_is_uart, w_is_eth, w_is_unmapped, w_is_mmio, w_req;
    logic w_pready;
    logic [31:0] w_prdata;

    assign w_is_uart     = (addr[31:3] == c_UART_WORD8);
    assign w_is_eth      = (addr[31:3] == c_ETH_WORD8);
    assign w_is_unmapped = (addr == c_UNMAPPED);
    assign w_is_mmio     = w_is_uart | w_is_eth | w_is_unmapped;
    assign w_req         = memread | memwrite;

    // Only the selected peripheral's handshake is ever looked at.
    assign w_pready = r_tgt_eth ? pready_eth : pready_uart;
    assign w_prdata = r_tgt_eth ? prdata_eth : prdata_uart;

    assign we_mem    = memwrite & ~w_is_mmio;
    assign stall     = ((r_state == S_IDLE) & w_req & w_is_mmio)
                     | (r_state == S_SETUP) | (r_state == S_ACCESS);
    assign psel_uart = ((r_state == S_SETUP) | (r_state == S_ACCESS)) & ~r_tgt_eth;
    assign psel_eth  = ((r_state == S_SETUP) | (r_state == S_ACCESS)) & r_tgt_eth;
    assign penable   = (r_state == S_ACCESS);
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign readdata  = r_readdata;
    assign bus_error = r_bus_error;

    always_comb begin
        w_state_nxt     = r_state;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;
        w_tgt_eth_nxt   = r_tgt_eth;
        w_count_nxt     = r_count;
        w_readdata_nxt  = r_readdata;
        w_bus_error_nxt = r_bus_error;
        case (r_state)
            S_IDLE: begin
                if (w_req && (w_is_uart || w_is_eth)) begin
                    w_paddr_nxt   = addr;
                    w_pwdata_nxt  = writedata;
                    w_pwrite_nxt  = memwrite;
                    w_tgt_eth_nxt = w_is_eth;
                    w_state_nxt   = S_SETUP;
                end else if (w_req && w_is_unmapped) begin
                    w_readdata_nxt  = 32'd0;
                    w_bus_error_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end
            S_SETUP: begin
                w_count_nxt = 8'd0;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_pready) begin
                    w_readdata_nxt  = r_pwrite ? 32'd0 : w_prdata;
                    w_bus_error_nxt = 1'b0;
                    w_count_nxt     = 8'd0;
                    w_state_nxt     = S_DONE;
                end else if (r_count == c_LAST_WAIT) begin
                    w_readdata_nxt  = 32'd0;
                    w_bus_error_nxt = 1'b1;
                    w_count_nxt     = 8'd0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_count_nxt = r_count + 8'd1;
                end
            end
            S_DONE: begin
                // The request still visible here is the one just completed.
                w_readdata_nxt  = 32'd0;
                w_bus_error_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_paddr     <= 32'd0;
            r_pwdata    <= 32'd0;
            r_pwrite    <= 1'b0;
            r_tgt_eth   <= 1'b0;
            r_count     <= 8'd0;
            r_readdata  <= 32'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_tgt_eth   <= w_tgt_eth_nxt;
            r_count     <= w_count_nxt;
            r_readdata  <= w_readdata_nxt;
            r_bus_error <= w_bus_error_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/mmio_bus_controller.md
MMIO_BUS_CONTROLLER -- requirements
Module: mmio_bus_controller

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, max ACCESS cycles waited for pready before abort (range 1..255).
REQ-002 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide memwrite  input  1  CPU store request.
REQ-005 SHALL provide memread  input  1  CPU load request.
REQ-006 SHALL provide addr  input  32  CPU byte address, word aligned.
REQ-007 SHALL provide writedata  input  32  CPU store data.
REQ-008 SHALL provide we_mem  output  1  data-memory write enable.
REQ-009 SHALL provide stall  output  1  holds CPU memory stage.
REQ-010 SHALL provide readdata  output  32  MMIO load result, valid in DONE.
REQ-011 SHALL provide bus_error  output  1  MMIO access failed, valid in DONE.
REQ-012 SHALL provide paddr  output  32  peripheral address.
REQ-013 SHALL provide pwdata  output  32  peripheral write data.
REQ-014 SHALL provide pwrite  output  1  1 = write, 0 = read.
REQ-015 SHALL provide psel_uart  output  1  UART select.
REQ-016 SHALL provide psel_eth  output  1  ethernet select.
REQ-017 SHALL provide penable  output  1  access phase strobe.
REQ-018 SHALL provide prdata_uart / prdata_eth  input  32 each  peripheral read data.
REQ-019 SHALL provide pready_uart / pready_eth  input  1 each  peripheral completion.

Function
REQ-020 SHALL decode: UART 0xFFFF0000-0xFFFF0007, ethernet 0xFFFF0008-0xFFFF000F, unmapped MMIO 0xFFFF0010; all other addresses are memory.
REQ-021 SHALL drive we_mem = memwrite AND address is memory, combinationally, with no stall; memory accesses never enter the FSM.
REQ-022 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-023 IDLE: on (memread OR memwrite) to UART/ethernet, SHALL latch paddr, pwdata=writedata, pwrite=memwrite, target; next SETUP.
REQ-024 IDLE: on a request to 0xFFFF0010, SHALL go directly to DONE with bus_error=1, readdata=0.
REQ-025 SETUP: SHALL assert selected psel, penable=0; next ACCESS unconditionally.
REQ-026 ACCESS: SHALL assert selected psel and penable=1; pready of the selected device only is sampled; the other pready is ignored.
REQ-027 ACCESS with pready=1: SHALL capture selected prdata into readdata (reads only; writes load 0), bus_error=0, next DONE.
REQ-028 ACCESS: SHALL count cycles; at TIMEOUT cycles without pready go to DONE with bus_error=1, readdata=0; counter cleared on leaving ACCESS.
REQ-029 DONE: psel/penable deasserted, stall=0, readdata/bus_error held; the request present in DONE is the completing one and SHALL be ignored; next IDLE.
REQ-030 stall SHALL be (IDLE AND MMIO request) OR SETUP OR ACCESS, combinational.
REQ-031 paddr, pwdata, pwrite SHALL remain stable from SETUP through ACCESS.
REQ-032 memwrite and memread both high SHALL be treated as a write.
REQ-033 readdata and bus_error SHALL be 0 outside DONE.
REQ-034 Zero-wait MMIO latency SHALL be 3 stall cycles (IDLE, SETUP, ACCESS) + DONE; unmapped MMIO latency SHALL be 1 stall cycle + DONE.

Reset
REQ-035 On reset low, the block SHALL asynchronously enter IDLE, clear the counter, and drive psel_uart, psel_eth, penable, pwrite, bus_error to 0 and paddr, pwdata, readdata to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no DONE cycle; after release the FSM SHALL resume in IDLE on the next edge.

Verification
REQ-037 Store 0x12345678 to 0x00001000 -> we_mem=1 same cycle, stall=0, no psel.
REQ-038 Load 0xFFFF0000, pready_uart=1, prdata_uart=0xA5 -> stall 3 cycles, psel_uart in SETUP+ACCESS, penable in ACCESS only, DONE readdata=0xA5, bus_error=0.
REQ-039 Store 0xCAFE to 0xFFFF0008, pready_eth low 4 cycles -> pwrite=1, pwdata=0xCAFE stable, psel_eth held, stall 7 cycles, DONE bus_error=0, readdata=0.
REQ-040 Load 0xFFFF000C, pready_eth never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, DONE bus_error=1, readdata=0.
REQ-041 Load 0xFFFF0010 -> stall 1 cycle, no psel, DONE bus_error=1.
REQ-042 Reset low during ACCESS -> psel/penable/stall drop immediately; next request after release sequences normally.
